// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: opcodes, FSM encoding,
// memory timeout and a small opcode-extraction helper.
package fetch_pkg;

   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_BEQ  = 4'hB;

   // Number of consecutive WAIT cycles without read data before a retry.
   localparam logic [3:0] TIMEOUT = 4'd15;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   function automatic logic [3:0] opcode_of(input logic [15:0] instr_word);
      return instr_word[15:12];
   endfunction

endpackage

// File: rtl/fetch_decode.sv
// Combinational decode of a fetched instruction into the PC control fields.
module fetch_decode
   import fetch_pkg::*;
(
   input  logic [15:0] i_instr,
   input  logic        i_cond_flag,
   output logic [7:0]  o_im,
   output logic        o_branch,
   output logic        o_nia
);

   logic [3:0] w_opcode;

   assign w_opcode = opcode_of(i_instr);
   assign o_im     = i_instr[7:0];

   // JMP loads the PC absolutely; BEQ branches relative when the zero flag is set.
   always_comb begin
      o_branch = 1'b0;
      o_nia    = 1'b1;
      case (w_opcode)
         OP_JMP:  o_nia    = 1'b0;
         OP_BEQ:  o_branch = i_cond_flag;
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one read per instruction, waits for data with
// a retry timeout, then holds the instruction until it is accepted or flushed.
module instr_fetch
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  pc_addr,
   output logic        pc_step,
   output logic        mem_req,
   output logic [7:0]  mem_addr,
   input  logic        mem_rvalid,
   input  logic [15:0] mem_rdata,
   input  logic        cond_flag,
   input  logic        flush,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [7:0]  im,
   output logic        branch,
   output logic        nia,
   output logic        err
);

   fetch_state_t r_state;
   logic [3:0]   r_cnt;
   logic         r_mem_req;
   logic [7:0]   r_mem_addr;
   logic [15:0]  r_instr;
   logic         r_instr_valid;
   logic         r_err;

   logic         w_hold;
   logic [7:0]   w_im;
   logic         w_branch;
   logic         w_nia;

   assign w_hold = (r_state == HOLD);

   fetch_decode u_decode (
      .i_instr     (r_instr),
      .i_cond_flag (cond_flag),
      .o_im        (w_im),
      .o_branch    (w_branch),
      .o_nia       (w_nia)
   );

   // Fetch sequencer; the read address is sampled from pc_addr on the edge that
   // enters REQ from IDLE or HOLD, and kept unchanged for a timeout retry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= IDLE;
         r_cnt         <= 4'd0;
         r_mem_req     <= 1'b0;
         r_mem_addr    <= 8'h00;
         r_instr       <= 16'h0000;
         r_instr_valid <= 1'b0;
         r_err         <= 1'b0;
      end else begin
         r_mem_req <= 1'b0;
         case (r_state)
            IDLE: begin
               r_state    <= REQ;
               r_mem_req  <= 1'b1;
               r_mem_addr <= pc_addr;
            end
            REQ: begin
               r_state <= WAIT;
               r_cnt   <= 4'd0;
            end
            WAIT: begin
               if (mem_rvalid) begin
                  r_instr       <= mem_rdata;
                  r_instr_valid <= 1'b1;
                  r_cnt         <= 4'd0;
                  r_state       <= HOLD;
               end else if (r_cnt == TIMEOUT - 4'd1) begin
                  r_err     <= 1'b1;
                  r_cnt     <= 4'd0;
                  r_mem_req <= 1'b1;
                  r_state   <= REQ;
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            HOLD: begin
               if (flush || instr_ready) begin
                  r_instr_valid <= 1'b0;
                  r_mem_req     <= 1'b1;
                  r_mem_addr    <= pc_addr;
                  r_state       <= REQ;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign mem_req     = r_mem_req;
   assign mem_addr    = r_mem_addr;
   assign instr       = r_instr;
   assign instr_valid = r_instr_valid;
   assign err         = r_err;

   // PC controls are only meaningful while an instruction is held.
   assign pc_step = w_hold & instr_ready & ~flush;
   assign im      = w_hold ? w_im : 8'h00;
   assign branch  = w_hold & w_branch;
   assign nia     = w_hold ? w_nia : 1'b1;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a decode vector table plus hand-written
// sequences for flush, timeout retry and reset in the middle of a read.
module tb_instr_fetch;

   logic        clk;
   logic        rst;
   logic [7:0]  pc_addr;
   logic        pc_step;
   logic        mem_req;
   logic [7:0]  mem_addr;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   logic        cond_flag;
   logic        flush;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_ready;
   logic [7:0]  im;
   logic        branch;
   logic        nia;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] rdata;
      logic        cond;
      logic [7:0]  exp_im;
      logic        exp_branch;
      logic        exp_nia;
   } vec_t;

   vec_t vecs[6];

   instr_fetch dut (
      .clk         (clk),
      .rst         (rst),
      .pc_addr     (pc_addr),
      .pc_step     (pc_step),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .cond_flag   (cond_flag),
      .flush       (flush),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .im          (im),
      .branch      (branch),
      .nia         (nia),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout req=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h req=%h", name, act, exp);
      end
   endtask

   task automatic check_reset();
      chk("rst_mem_req",     32'(mem_req),     32'd0);
      chk("rst_mem_addr",    32'(mem_addr),    32'h00);
      chk("rst_instr",       32'(instr),       32'h0000);
      chk("rst_instr_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc_step",     32'(pc_step),     32'd0);
      chk("rst_im",          32'(im),          32'h00);
      chk("rst_branch",      32'(branch),      32'd0);
      chk("rst_nia",         32'(nia),         32'd1);
      chk("rst_err",         32'(err),         32'd0);
   endtask

   // Expects to be in (or shortly reach) the REQ cycle.
   task automatic wait_req(input logic [7:0] exp_addr);
      int i = 0;
      while (mem_req !== 1'b1 && i < 20) begin
         tick();
         i++;
      end
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
   endtask

   // From the REQ cycle: return read data with one cycle of memory latency.
   task automatic deliver(input logic [15:0] rdata);
      tick();
      chk("req_pulse_end", 32'(mem_req), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = rdata;
      tick();
      mem_rvalid = 1'b0;
      #1;
   endtask

   task automatic check_hold(input logic [15:0] e_instr, input logic [7:0] e_im,
                             input logic e_branch, input logic e_nia);
      chk("instr_valid", 32'(instr_valid), 32'd1);
      chk("instr",       32'(instr),       32'(e_instr));
      chk("im",          32'(im),          32'(e_im));
      chk("branch",      32'(branch),      32'(e_branch));
      chk("nia",         32'(nia),         32'(e_nia));
      chk("pc_step_idle", 32'(pc_step),    32'd0);
   endtask

   task automatic accept();
      instr_ready = 1'b1;
      #1;
      chk("pc_step_accept", 32'(pc_step), 32'd1);
      tick();
      instr_ready = 1'b0;
      #1;
      chk("pc_step_after", 32'(pc_step), 32'd0);
   endtask

   initial begin
      vecs[0] = '{8'h20, 16'hC042, 1'b0, 8'h42, 1'b0, 1'b0};
      vecs[1] = '{8'h21, 16'hB005, 1'b1, 8'h05, 1'b1, 1'b1};
      vecs[2] = '{8'h22, 16'hB005, 1'b0, 8'h05, 1'b0, 1'b1};
      vecs[3] = '{8'hFF, 16'h7ABC, 1'b1, 8'hBC, 1'b0, 1'b1};
      vecs[4] = '{8'h00, 16'hC0FF, 1'b1, 8'hFF, 1'b0, 1'b0};
      vecs[5] = '{8'h01, 16'hB3A7, 1'b1, 8'hA7, 1'b1, 1'b1};

      rst         = 1'b1;
      pc_addr     = 8'h10;
      mem_rvalid  = 1'b0;
      mem_rdata   = 16'h0000;
      cond_flag   = 1'b0;
      flush       = 1'b0;
      instr_ready = 1'b0;

      // Reset state
      repeat (3) tick();
      check_reset();
      $display("reset: outputs at reset values checked");

      // First fetch after reset release
      rst = 1'b0;
      #1;
      chk("idle_no_req", 32'(mem_req), 32'd0);
      tick();
      wait_req(8'h10);
      deliver(16'h1203);
      check_hold(16'h1203, 8'h03, 1'b0, 1'b1);
      tick();
      chk("hold_stable_valid", 32'(instr_valid), 32'd1);
      chk("hold_stable_instr", 32'(instr), 32'h1203);
      $display("fetch addr=10 instr=%h valid=%0d", instr, instr_valid);

      // Table of decode vectors, each fetched after accepting the previous one
      for (int v = 0; v < 6; v++) begin
         pc_addr   = vecs[v].addr;
         cond_flag = vecs[v].cond;
         accept();
         wait_req(vecs[v].addr);
         deliver(vecs[v].rdata);
         check_hold(vecs[v].rdata, vecs[v].exp_im, vecs[v].exp_branch, vecs[v].exp_nia);
         $display("vec %0d addr=%h rdata=%h cond=%0d -> im=%h branch=%0d nia=%0d",
                  v, mem_addr, instr, cond_flag, im, branch, nia);
      end

      // BEQ with cond_flag changing while held
      pc_addr   = 8'h30;
      cond_flag = 1'b0;
      accept();
      wait_req(8'h30);
      deliver(16'hB005);
      cond_flag = 1'b1;
      #1;
      chk("beq_branch_hi", 32'(branch), 32'd1);
      cond_flag = 1'b0;
      #1;
      chk("beq_branch_lo", 32'(branch), 32'd0);
      chk("beq_nia", 32'(nia), 32'd1);
      chk("beq_im", 32'(im), 32'h05);
      tick();
      chk("beq_stable", 32'(instr), 32'hB005);
      $display("beq toggle: branch followed cond_flag, instr=%h", instr);

      // Flush wins over instr_ready
      flush       = 1'b1;
      instr_ready = 1'b1;
      #1;
      chk("flush_no_step", 32'(pc_step), 32'd0);
      tick();
      flush       = 1'b0;
      instr_ready = 1'b0;
      #1;
      chk("flush_dropped", 32'(instr_valid), 32'd0);
      wait_req(8'h30);
      $display("flush: refetch addr=%h", mem_addr);

      // Flush outside HOLD has no effect
      tick();
      flush      = 1'b1;
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h2468;
      tick();
      flush      = 1'b0;
      mem_rvalid = 1'b0;
      #1;
      chk("flush_wait_valid", 32'(instr_valid), 32'd1);
      chk("flush_wait_instr", 32'(instr), 32'h2468);
      $display("flush in WAIT ignored: instr=%h", instr);

      // Timeout: 15 WAIT cycles without data trigger err and a retry
      pc_addr = 8'h31;
      accept();
      wait_req(8'h31);
      tick();
      repeat (14) tick();
      chk("to_err_before", 32'(err), 32'd0);
      chk("to_req_before", 32'(mem_req), 32'd0);
      tick();
      chk("to_err", 32'(err), 32'd1);
      chk("to_retry_req", 32'(mem_req), 32'd1);
      chk("to_retry_addr", 32'(mem_addr), 32'h31);
      deliver(16'h1111);
      check_hold(16'h1111, 8'h11, 1'b0, 1'b1);
      chk("to_err_sticky", 32'(err), 32'd1);
      accept();
      chk("to_err_sticky2", 32'(err), 32'd1);
      $display("timeout: err=%0d retry addr=31", err);

      // Reset in the middle of WAIT, late rvalid after release
      tick();
      tick();
      rst = 1'b1;
      #1;
      check_reset();
      tick();
      rst        = 1'b0;
      mem_rvalid = 1'b1;
      mem_rdata  = 16'hDEAD;
      #1;
      chk("late_idle_instr", 32'(instr), 32'h0000);
      tick();
      chk("restart_req", 32'(mem_req), 32'd1);
      chk("late_instr", 32'(instr), 32'h0000);
      chk("late_valid", 32'(instr_valid), 32'd0);
      chk("late_err", 32'(err), 32'd0);
      mem_rvalid = 1'b0;
      tick();
      chk("late_wait_valid", 32'(instr_valid), 32'd0);
      mem_rvalid = 1'b1;
      mem_rdata  = 16'h5A5A;
      tick();
      mem_rvalid = 1'b0;
      #1;
      chk("restart_valid", 32'(instr_valid), 32'd1);
      chk("restart_instr", 32'(instr), 32'h5A5A);
      $display("reset mid-wait: restart fetched instr=%h", instr);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
